// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg : shared constants, index type and clog2 helper for the
//                registered priority encoder.
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

package prio_enc_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [1:0] idx4_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc_core.sv
// -----------------------------------------------------------------------------
// prio_enc_core : combinational priority encoder, highest set request wins.
//                 Optional one-hot output built with PRIO_ENC_ONEHOT_EN.
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] I,
    input  logic             E,
    output logic [IDX_W-1:0] y_nxt,
`ifdef PRIO_ENC_ONEHOT_EN
    output logic [WIDTH-1:0] oh_nxt,
`endif
    output logic             v_nxt
);

    logic [WIDTH-1:0] w_oh;

    // Enable is tested before any request bit so unknowns on I cannot leak
    // through while the encoder is disabled.
    always_comb begin
        y_nxt = '0;
        v_nxt = 1'b0;
        w_oh  = '0;
        if (E) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (!v_nxt && I[i]) begin
                    y_nxt   = IDX_W'(i);
                    v_nxt   = 1'b1;
                    w_oh[i] = 1'b1;
                end
            end
        end
    end

`ifdef PRIO_ENC_ONEHOT_EN
    assign oh_nxt = w_oh;
`else
    logic w_oh_unused;
    assign w_oh_unused = ^w_oh;
`endif

endmodule

`default_nettype wire

// File: rtl/prio_enc_4to2_reg.sv
// -----------------------------------------------------------------------------
// prio_enc_4to2_reg : registered priority encoder (index + valid, 1-cycle
//                     latency). Macro PRIO_ENC_ONEHOT_EN adds output Y_OH.
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module prio_enc_4to2_reg
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    input  logic             E,
    output logic [IDX_W-1:0] Y,
`ifdef PRIO_ENC_ONEHOT_EN
    output logic [WIDTH-1:0] Y_OH,
`endif
    output logic             V
);

    logic [IDX_W-1:0] y_d;
    logic [IDX_W-1:0] y_q;
    logic             v_d;
    logic             v_q;

`ifdef PRIO_ENC_ONEHOT_EN
    logic [WIDTH-1:0] oh_d;
    logic [WIDTH-1:0] oh_q;
`endif

    prio_enc_core #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_core (
        .I      (I),
        .E      (E),
        .y_nxt  (y_d),
`ifdef PRIO_ENC_ONEHOT_EN
        .oh_nxt (oh_d),
`endif
        .v_nxt  (v_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
            v_q <= 1'b0;
        end else begin
            y_q <= y_d;
            v_q <= v_d;
        end
    end

`ifdef PRIO_ENC_ONEHOT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            oh_q <= '0;
        end else begin
            oh_q <= oh_d;
        end
    end

    assign Y_OH = oh_q;
`endif

    assign Y = y_q;
    assign V = v_q;

endmodule

`default_nettype wire

// File: tb/tb_prio_enc_4to2_reg.sv
// -----------------------------------------------------------------------------
// tb_prio_enc_4to2_reg : scoreboard bench for prio_enc_4to2_reg, directed
//                        cases followed by random stimulus.
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_prio_enc_4to2_reg;

    logic       clk;
    logic       rst;
    logic [3:0] I;
    logic       E;
    logic [1:0] Y;
    logic       V;
`ifdef PRIO_ENC_ONEHOT_EN
    logic [3:0] Y_OH;
`endif

    typedef struct {
        logic [1:0] y;
        logic       v;
        logic [3:0] oh;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    prio_enc_4to2_reg dut (
        .clk  (clk),
        .rst  (rst),
        .I    (I),
        .E    (E),
        .Y    (Y),
`ifdef PRIO_ENC_ONEHOT_EN
        .Y_OH (Y_OH),
`endif
        .V    (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the winner is floor(log2(I)) of the request vector read as a number.
    function automatic exp_t model(input logic r, input logic e, input logic [3:0] i);
        exp_t x;
        int   n;
        int   idx;
        x.y  = 2'd0;
        x.v  = 1'b0;
        x.oh = 4'd0;
        if (r || !e) return x;
        if (i == 4'd0) return x;
        n   = int'(i);
        idx = 0;
        while (n > 1) begin
            n   = n / 2;
            idx = idx + 1;
        end
        x.y  = 2'(idx);
        x.v  = 1'b1;
        x.oh = 4'(1 << idx);
        return x;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [3:0] i);
        @(negedge clk);
        rst = r;
        E   = e;
        I   = i;
        exp_q.push_back(model(r, e, i));
    endtask

    // Monitor: every edge presents a result; compare it with the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                total++;
                if (Y !== x.y) begin
                    bad++;
                    $display("FAIL Y at %0t: got %b want %b", $time, Y, x.y);
                end
                total++;
                if (V !== x.v) begin
                    bad++;
                    $display("FAIL V at %0t: got %b want %b", $time, V, x.v);
                end
`ifdef PRIO_ENC_ONEHOT_EN
                total++;
                if (Y_OH !== x.oh) begin
                    bad++;
                    $display("FAIL Y_OH at %0t: got %b want %b", $time, Y_OH, x.oh);
                end
`endif
            end
        end
    end

    initial begin
        rst = 1'b1;
        E   = 1'b1;
        I   = 4'b1111;

        drive(1'b1, 1'b1, 4'b1111);
        drive(1'b1, 1'b1, 4'b1111);
        drive(1'b0, 1'b1, 4'b1111);

        drive(1'b0, 1'b0, 4'b0001);
        drive(1'b0, 1'b0, 4'b0110);
        drive(1'b0, 1'b0, 4'bxxxx);
        drive(1'b0, 1'b1, 4'b0000);

        for (int k = 1; k < 16; k++) drive(1'b0, 1'b1, 4'(k));

        drive(1'b0, 1'b1, 4'b1001);
        drive(1'b0, 1'b1, 4'b0101);
        drive(1'b0, 1'b1, 4'b0011);
        drive(1'b0, 1'b1, 4'b0110);
        drive(1'b0, 1'b0, 4'b0110);

        // Mid-stream reset followed by a valid request right after release.
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b1, 1'b1, 4'b1000);
        drive(1'b0, 1'b1, 4'b0100);

        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(15) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                  4'($urandom_range(15)));
        end

        repeat (4) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
